// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate strobe, beam position, sync pulses and
// video window, all registered together so they stay zero-skew.
module vga_sync_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int TICK_DIV  = 2,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic       pixel_tick,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
   localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic          tick_q, tick_d;
   logic [9:0]    h_q, h_d, v_q, v_d;
   logic          fs_q, fs_d;
   logic          von_q, von_d;
   logic          hs_q, hs_d, vs_q, vs_d;

   // Next-state: the tick is the registered decode of the divider's last
   // count, and the beam moves on the edge that closes a tick cycle.
   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      h_d    = h_q;
      v_d    = v_q;
      fs_d   = 1'b0;
      if (en) begin
         div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
         tick_d = (div_q == DIV_LAST);
         if (tick_q) begin
            if (h_q == H_LAST) begin
               h_d  = 10'd0;
               v_d  = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
               fs_d = (v_q == V_LAST);
            end else begin
               h_d = h_q + 10'd1;
            end
         end else begin
            h_d = h_q;
         end
      end else begin
         div_d = div_q;
      end
      // Decoded from the next position so they land on the same edge as it.
      hs_d  = ((h_d >= HS_START) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = ((v_d >= VS_START) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      von_d = (h_d < H_DISP) && (v_d < V_DISP);
   end

   // State and registered outputs; reset dominates enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
         h_q    <= 10'd0;
         v_q    <= 10'd0;
         fs_q   <= 1'b0;
         von_q  <= 1'b1;
         hs_q   <= ~SYNC_POL;
         vs_q   <= ~SYNC_POL;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
         h_q    <= h_d;
         v_q    <= v_d;
         fs_q   <= fs_d;
         von_q  <= von_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
      end
   end

   assign pixel_tick  = tick_q;
   assign pix_x       = h_q;
   assign pix_y       = v_q;
   assign video_on    = von_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a tiny TICK_DIV=1,
// active-high-sync instance, both compared every cycle to a position model.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, en0, rst1, en1;
   logic       tick0, vid0, hs0, vs0, fs0;
   logic       tick1, vid1, hs1, vs1, fs1;
   logic [9:0] px0, py0, px1, py1;

   int n_chk  = 0;
   int n_pass = 0;

   vga_sync_gen u_def (
      .clk(clk), .reset(rst0), .en(en0), .pixel_tick(tick0), .pix_x(px0),
      .pix_y(py0), .video_on(vid0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
   );

   vga_sync_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .TICK_DIV(1), .SYNC_POL(1'b1)
   ) u_small (
      .clk(clk), .reset(rst1), .en(en1), .pixel_tick(tick1), .pix_x(px1),
      .pix_y(py1), .video_on(vid1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
   );

   // Per-instance timing: {HD, HF, HS, HB, VD, VF, VS, VB, TD, POL}
   int prm [2][10] = '{'{640, 16, 96, 48, 480, 10, 2, 33, 2, 0},
                       '{8, 2, 3, 2, 4, 1, 2, 1, 1, 1}};

   // Model: count of enabled clocks since reset and of pixels consumed.
   int kcnt [2];
   int consumed [2];
   bit mtick [2];
   bit mfs [2];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int h_total(input int i);
      return prm[i][0] + prm[i][1] + prm[i][2] + prm[i][3];
   endfunction

   function automatic int v_total(input int i);
      return prm[i][4] + prm[i][5] + prm[i][6] + prm[i][7];
   endfunction

   function automatic int mx(input int i);
      return consumed[i] % h_total(i);
   endfunction

   function automatic int my(input int i);
      return (consumed[i] / h_total(i)) % v_total(i);
   endfunction

   task automatic model_edge(input int i, input bit r, input bit e);
      bit adv;
      if (r) begin
         kcnt[i] = 0; consumed[i] = 0; mtick[i] = 1'b0; mfs[i] = 1'b0;
      end else if (e) begin
         adv = mtick[i];
         kcnt[i]++;
         mtick[i] = (kcnt[i] % prm[i][8]) == 0;
         if (adv) consumed[i]++;
         mfs[i] = adv && (consumed[i] % (h_total(i) * v_total(i)) == 0);
      end else begin
         mtick[i] = 1'b0; mfs[i] = 1'b0;
      end
   endtask

   task automatic check_inst(input int i);
      int x, y, hs_lo, vs_lo, act, ox, oy, ot, ov, oh, ovs, of;
      x = mx(i); y = my(i);
      hs_lo = prm[i][0] + prm[i][1];
      vs_lo = prm[i][4] + prm[i][5];
      act = prm[i][9];
      if (i == 0) begin
         ox = px0; oy = py0; ot = tick0; ov = vid0; oh = hs0; ovs = vs0; of = fs0;
      end else begin
         ox = px1; oy = py1; ot = tick1; ov = vid1; oh = hs1; ovs = vs1; of = fs1;
      end
      chk($sformatf("pix_x[%0d]", i), ox, x);
      chk($sformatf("pix_y[%0d]", i), oy, y);
      chk($sformatf("pixel_tick[%0d]", i), ot, int'(mtick[i]));
      chk($sformatf("frame_start[%0d]", i), of, int'(mfs[i]));
      chk($sformatf("video_on[%0d]", i), ov, (x < prm[i][0] && y < prm[i][4]) ? 1 : 0);
      chk($sformatf("hsync[%0d]", i), oh,
          (x >= hs_lo && x < hs_lo + prm[i][2]) ? act : 1 - act);
      chk($sformatf("vsync[%0d]", i), ovs,
          (y >= vs_lo && y < vs_lo + prm[i][6]) ? act : 1 - act);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0, rst0, en0);
      model_edge(1, rst1, en1);
      #1;
      check_inst(0);
      check_inst(1);
   endtask

   initial begin
      int n;
      int ticks;
      rst0 = 1'b1; en0 = 1'b0; rst1 = 1'b1; en1 = 1'b0;
      repeat (3) step();
      rst0 = 1'b0; en0 = 1'b1; rst1 = 1'b0; en1 = 1'b1;

      // Run to mid-line, then a 3-clock reset.
      for (n = 0; n < 5000 && mx(0) != 300; n++) step();
      chk("reach_x300", px0, 300);
      rst0 = 1'b1;
      repeat (3) step();
      rst0 = 1'b0;

      // Tick cadence right after release.
      ticks = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         ticks += int'(tick0);
      end
      chk("ticks_in_40clk", ticks, 20);

      // Freeze at x=100 for 10 clocks.
      for (n = 0; n < 5000 && mx(0) != 100; n++) step();
      chk("reach_x100", px0, 100);
      en0 = 1'b0;
      repeat (10) step();
      chk("frozen_x100", px0, 100);
      en0 = 1'b1;

      // Several full lines: line wrap and hsync window on the default instance.
      repeat (3400) step();
      chk("after_lines_y", py0, my(0));

      // Randomized enable and occasional reset on both instances.
      for (int c = 0; c < 6000; c++) begin
         en0  = ($urandom_range(0, 3) != 0);
         en1  = ($urandom_range(0, 3) != 0);
         rst0 = ($urandom_range(0, 299) == 0);
         rst1 = ($urandom_range(0, 499) == 0);
         step();
      end
      rst0 = 1'b0; rst1 = 1'b0; en0 = 1'b1; en1 = 1'b1;
      repeat (400) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
